haraka_mix_pipe: RTL and testbench



---
 rtl/haraka_pkg.sv | 26 ++
 rtl/haraka_mix_perm.sv | 33 +++
 rtl/haraka_mix_pipe.sv | 115 +++++++++++
 tb/tb_haraka_mix_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haraka_pkg.sv
// Shared constants, types and word-permutation tables for the Haraka MIX datapath.
package haraka_pkg;

  localparam int WORD_W         = 32;
  localparam int STATE512_WORDS = 16;
  localparam int STATE256_WORDS = 8;
  localparam int STATE_W        = STATE512_WORDS * WORD_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    MIX256 = 1'b0,
    MIX512 = 1'b1
  } mix_mode_e;

  // Forward tables: output word j takes input word P[j].
  localparam logic [3:0] MIX512_P [STATE512_WORDS] = '{
    4'd3, 4'd11, 4'd7, 4'd15, 4'd8, 4'd0, 4'd12, 4'd4,
    4'd9, 4'd1,  4'd13, 4'd5, 4'd2, 4'd10, 4'd6, 4'd14
  };

  localparam logic [3:0] MIX256_P [STATE256_WORDS] = '{
    4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7
  };

endpackage

// File: rtl/haraka_mix_perm.sv
// Combinational Mix256/Mix512 word shuffle, forward or inverse.
module haraka_mix_perm
  import haraka_pkg::*;
(
  input  logic [STATE_W-1:0] data,
  input  mix_mode_e          mode,
  input  logic               inv,
  output logic [STATE_W-1:0] result
);

  // Word routing; Mix256 leaves words 8..15 at zero through the default.
  always_comb begin
    result = '0;
    if (mode == MIX512) begin
      for (int j = 0; j < STATE512_WORDS; j++) begin
        if (inv) begin
          result[WORD_W*int'(MIX512_P[j]) +: WORD_W] = data[WORD_W*j +: WORD_W];
        end else begin
          result[WORD_W*j +: WORD_W] = data[WORD_W*int'(MIX512_P[j]) +: WORD_W];
        end
      end
    end else begin
      for (int j = 0; j < STATE256_WORDS; j++) begin
        if (inv) begin
          result[WORD_W*int'(MIX256_P[j]) +: WORD_W] = data[WORD_W*j +: WORD_W];
        end else begin
          result[WORD_W*j +: WORD_W] = data[WORD_W*int'(MIX256_P[j]) +: WORD_W];
        end
      end
    end
  end

endmodule

// File: rtl/haraka_mix_pipe.sv
// Elastic STAGES-deep pipeline around the Haraka MIX permutation with a sideband tag.
// Optional performance counters are enabled by defining HARAKA_MIX_PERF_EN.
module haraka_mix_pipe
  import haraka_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_mode,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef HARAKA_MIX_PERF_EN
  ,
  output logic [31:0]        perf_xfers,
  output logic [31:0]        perf_stalls
`endif
);

  logic [STATE_W-1:0] perm_s;
  logic [STAGES-1:0]  v_r;
  logic [STAGES-1:0]  adv_s;
  logic [STAGES-1:0]  src_v_s;
  logic [STATE_W-1:0] d_r     [STAGES];
  logic [STATE_W-1:0] src_d_s [STAGES];
  logic [TAG_W-1:0]   t_r     [STAGES];
  logic [TAG_W-1:0]   src_t_s [STAGES];

  haraka_mix_perm u_perm (
    .data   (in_data),
    .mode   (mix_mode_e'(in_mode)),
    .inv    (in_inv),
    .result (perm_s)
  );

  // Ready chain from the output back to stage 0; a stage loads when empty or draining.
  always_comb begin
    logic acc_s;
    acc_s = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc_s    = !v_r[s] || acc_s;
      adv_s[s] = acc_s;
    end
  end

  // Source of each slice: the permuted input for stage 0, the previous slice otherwise.
  always_comb begin
    src_v_s[0] = in_valid;
    src_d_s[0] = perm_s;
    src_t_s[0] = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      src_v_s[s] = v_r[s-1];
      src_d_s[s] = d_r[s-1];
      src_t_s[s] = t_r[s-1];
    end
  end

  // Elastic register slices; payload only moves with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_r[s] <= 1'b0;
        d_r[s] <= '0;
        t_r[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv_s[s]) begin
          v_r[s] <= src_v_s[s];
          if (src_v_s[s]) begin
            d_r[s] <= src_d_s[s];
            t_r[s] <= src_t_s[s];
          end
        end
      end
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = v_r[STAGES-1];
  assign out_data  = d_r[STAGES-1];
  assign out_tag   = t_r[STAGES-1];

`ifdef HARAKA_MIX_PERF_EN
  logic [31:0] xfers_r;
  logic [31:0] stalls_r;

  // Output transfer and backpressure-stall counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfers_r  <= 32'd0;
      stalls_r <= 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        xfers_r <= xfers_r + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stalls_r <= stalls_r + 32'd1;
      end
    end
  end

  assign perf_xfers  = xfers_r;
  assign perf_stalls = stalls_r;
`endif

endmodule

// File: tb/tb_haraka_mix_pipe.sv
// Self-checking bench: STAGES=1 instance for permutation checks, STAGES=2 for flow control.
`timescale 1ns/1ps
module tb_haraka_mix_pipe;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_in_mode, a_in_inv, a_out_valid, a_out_ready;
  logic [511:0] a_in_data, a_out_data;
  logic [3:0]   a_in_tag, a_out_tag;
  logic         b_in_valid, b_in_ready, b_in_mode, b_in_inv, b_out_valid, b_out_ready;
  logic [511:0] b_in_data, b_out_data;
  logic [3:0]   b_in_tag, b_out_tag;
`ifdef HARAKA_MIX_PERF_EN
  logic [31:0]  a_perf_xfers, a_perf_stalls, b_perf_xfers, b_perf_stalls;
`endif

  haraka_mix_pipe #(.STAGES(1), .TAG_W(TAG_W)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_inv(a_in_inv), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag)
`ifdef HARAKA_MIX_PERF_EN
    , .perf_xfers(a_perf_xfers), .perf_stalls(a_perf_stalls)
`endif
  );

  haraka_mix_pipe #(.STAGES(2), .TAG_W(TAG_W)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_inv(b_in_inv), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
`ifdef HARAKA_MIX_PERF_EN
    , .perf_xfers(b_perf_xfers), .perf_stalls(b_perf_stalls)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  int P512 [16] = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};
  int P256 [8]  = '{0, 4, 1, 5, 2, 6, 3, 7};

  typedef struct {
    logic [511:0] d;
    logic [3:0]   t;
  } exp_t;
  exp_t q[$];

  logic [511:0] item_d [16];
  logic         item_m [16];
  logic         item_i [16];
  logic [3:0]   item_t [16];
  int  b_xfers = 0;
  int  b_stalls = 0;
  bit  b_prev_block = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: forward reads word P[j]; inverse searches the table for the word landing at j.
  function automatic logic [511:0] mix_ref(input logic [511:0] x, input bit mode, input bit inv);
    logic [511:0] y;
    int n;
    int p [16];
    y = '0;
    n = mode ? 16 : 8;
    for (int j = 0; j < n; j++) p[j] = mode ? P512[j] : P256[j];
    for (int j = 0; j < n; j++) begin
      int src;
      src = p[j];
      if (inv) begin
        for (int k = 0; k < n; k++) if (p[k] == j) src = k;
      end
      y[32*j +: 32] = x[32*src +: 32];
    end
    return y;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  // Called at a negedge: present one beat to the STAGES=1 instance and check it one cycle later.
  task automatic a_send(input logic [511:0] d, input bit mode, input bit inv,
                        input logic [3:0] tag, input logic [511:0] exp, input string name);
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = mode; a_in_inv = inv; a_in_tag = tag;
    #1 chk({name, "_in_ready"}, a_in_ready, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk({name, "_out_valid"}, a_out_valid, 1'b1);
    chk({name, "_out_data"}, a_out_data, exp);
    chk({name, "_out_tag"}, a_out_tag, tag);
  endtask

  task automatic b_drive(input int idx, input int n);
    if (idx < n) begin
      b_in_valid = 1'b1; b_in_data = item_d[idx]; b_in_mode = item_m[idx];
      b_in_inv = item_i[idx]; b_in_tag = item_t[idx];
    end else begin
      b_in_valid = 1'b0;
    end
  endtask

  // One cycle of the STAGES=2 instance: sample, score, then move to the next negedge.
  task automatic b_step(output bit acc, output bit emit);
    #1;
    if (b_prev_block) chk("b_valid_held", b_in_valid, 1'b1);
    acc  = b_in_valid && b_in_ready;
    emit = b_out_valid && b_out_ready;
    b_prev_block = b_in_valid && !b_in_ready;
    if (b_out_valid && !b_out_ready) begin
      b_stalls++;
      if (q.size() > 0) chk("b_stall_hold", b_out_data, q[0].d);
    end
    if (emit) begin
      b_xfers++;
      if (q.size() == 0) begin
        chk("b_spurious_out", b_out_valid, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("b_out_data", b_out_data, e.d);
        chk("b_out_tag", b_out_tag, e.t);
      end
    end
    if (acc) q.push_back('{mix_ref(b_in_data, b_in_mode, b_in_inv), b_in_tag});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] x, y, d;
    bit acc, emit;
    int sent, cycles, x0;
    bit m, iv;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_in_inv = 1'b0; a_in_tag = '0;
    a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_inv = 1'b0; b_in_tag = '0;
    b_out_ready = 1'b1;
    #12;
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_data", a_out_data, '0);
    chk("rst_a_out_tag", a_out_tag, '0);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_b_out_valid", b_out_valid, 1'b0);
    chk("post_rst_b_in_ready", b_in_ready, 1'b1);
    @(negedge clk);

    // Mix512 forward on word k = k.
    for (int k = 0; k < 16; k++) d[32*k +: 32] = k;
    a_send(d, 1'b1, 1'b0, 4'h5, mix_ref(d, 1'b1, 1'b0), "mix512_idx");
    chk("mix512_w0", a_out_data[31:0], 32'd3);
    chk("mix512_w1", a_out_data[63:32], 32'd11);
    chk("mix512_w15", a_out_data[511:480], 32'd14);

    // Mix256 forward on word k = 0xA0+k.
    for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'hA0 + k;
    a_send(d, 1'b0, 1'b0, 4'hA, mix_ref(d, 1'b0, 1'b0), "mix256_a0");
    chk("mix256_w1", a_out_data[63:32], 32'hA4);
    chk("mix256_w6", a_out_data[223:192], 32'hA3);
    chk("mix256_hi_zero", a_out_data[511:256], '0);

    // Round trips: feed the reference forward result through the inverse.
    x = rnd512();
    y = mix_ref(x, 1'b1, 1'b0);
    a_send(y, 1'b1, 1'b1, 4'h3, x, "rt512");
    x = rnd512();
    y = mix_ref(x, 1'b0, 1'b0);
    a_send(y, 1'b0, 1'b1, 4'hC, {256'd0, x[255:0]}, "rt256");

    for (int i = 0; i < 16; i++) begin
      d = rnd512(); m = 1'($urandom_range(0, 1)); iv = 1'($urandom_range(0, 1));
      a_send(d, m, iv, 4'($urandom_range(0, 15)), mix_ref(d, m, iv), "a_rand");
    end

    // STAGES=2 latency: visible after exactly two edges.
    item_d[0] = rnd512(); item_m[0] = 1'b1; item_i[0] = 1'b0; item_t[0] = 4'h9;
    b_out_ready = 1'b1;
    b_drive(0, 1);
    b_step(acc, emit);
    chk("b_lat_accept", acc, 1'b1);
    b_drive(1, 1);
    #1 chk("b_lat_early", b_out_valid, 1'b0);
    b_step(acc, emit);
    #1 chk("b_lat_valid", b_out_valid, 1'b1);
    b_step(acc, emit);
    chk("b_lat_emit", emit, 1'b1);

    // Backpressure: four beats, output stalled for six cycles.
    for (int i = 0; i < 4; i++) begin
      item_d[i] = rnd512(); item_m[i] = 1'($urandom_range(0, 1));
      item_i[i] = 1'($urandom_range(0, 1)); item_t[i] = 4'(i + 1);
    end
    sent = 0;
    b_out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      b_drive(sent, 4);
      b_step(acc, emit);
      if (acc) sent++;
    end
    chk("bp_accepts", sent, 2);
    b_drive(sent, 4);
    #1 chk("bp_in_ready_low", b_in_ready, 1'b0);
    chk("bp_out_valid", b_out_valid, 1'b1);
    b_out_ready = 1'b1;
    x0 = b_xfers;
    cycles = 0;
    while ((b_xfers - x0) < 4 && cycles < 20) begin
      b_drive(sent, 4);
      b_step(acc, emit);
      if (acc) sent++;
      cycles++;
    end
    chk("bp_drain_cycles", cycles, 4);
    chk("bp_queue_empty", q.size(), 0);

    // Continuous input, output ready toggling 1,0,1,0.
    for (int i = 0; i < 12; i++) begin
      item_d[i] = rnd512(); item_m[i] = 1'($urandom_range(0, 1));
      item_i[i] = 1'($urandom_range(0, 1)); item_t[i] = 4'(i);
    end
    sent = 0;
    x0 = b_xfers;
    cycles = 0;
    while ((b_xfers - x0) < 12 && cycles < 100) begin
      b_out_ready = ((cycles % 2) == 0);
      b_drive(sent, 12);
      b_step(acc, emit);
      if (acc) sent++;
      cycles++;
    end
    chk("tog_emitted", b_xfers - x0, 12);
    chk("tog_queue_empty", q.size(), 0);
    b_out_ready = 1'b1;
    b_drive(0, 0);
    b_step(acc, emit);
`ifdef HARAKA_MIX_PERF_EN
    chk("perf_xfers", b_perf_xfers, b_xfers);
    chk("perf_stalls", b_perf_stalls, b_stalls);
`endif

    // Asynchronous reset mid-cycle with two beats in flight.
    for (int i = 0; i < 2; i++) begin
      item_d[i] = rnd512(); item_m[i] = 1'b1; item_i[i] = 1'b0; item_t[i] = 4'(i + 7);
    end
    b_out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 2; c++) begin
      b_drive(sent, 2);
      b_step(acc, emit);
      if (acc) sent++;
    end
    b_drive(sent, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", b_out_valid, 1'b0);
    chk("arst_in_ready", b_in_ready, 1'b1);
    chk("arst_out_data", b_out_data, '0);
    chk("arst_out_tag", b_out_tag, '0);
    q.delete();
    b_prev_block = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b_out_ready = 1'b1;
`ifdef HARAKA_MIX_PERF_EN
    #1 chk("arst_perf_xfers", b_perf_xfers, 32'd0);
`endif
    for (int c = 0; c < 4; c++) begin
      #1 chk("arst_no_stale", b_out_valid, 1'b0);
      b_step(acc, emit);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
